uart_rx: RTL and testbench

Asynchronous serial receiver: 8N1 frames (optionally 8E1) on a single `rxd` line, 16x oversampled with majority voting, delivered as parallel words over a valid/ready output handshake. Sits between the board RX pin and the core's command/data path, and is the receive end of the project's UART link. Reports framing errors, parity errors and overruns as single-cycle pulses.

---
 rtl/util_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 25 ++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
// util_pkg: shared UART types, constants and the baud divider helper.
package util_pkg;

    localparam int UART_OVS_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_e;

    // Rounded clocks-per-oversample-tick: round(clk_hz / (baud * ovs)).
    function automatic int uart_div_f(input int clk_hz, input int baud, input int ovs);
        return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divide-by-DIV strobe generator with synchronous restart.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_restart   : realign the divider; no tick in the restart cycle
//   o_tick      : one-cycle strobe every DIV clocks
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (i_restart || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    assign o_tick = !i_restart && r_cnt == LAST;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
//   clk, rst_n   : clock, asynchronous active-low reset
//   rxd          : serial input, idle high, asynchronous
//   data_o       : received word, LSB first on the line
//   valid_o      : data_o holds an unconsumed word
//   ready_i      : consumer accepts on valid_o && ready_i
//   frame_err_o  : pulse, stop bit sampled low
//   parity_err_o : pulse, even parity mismatch (constant 0 without UART_RX_PARITY_EN)
//   overrun_o    : pulse, good word dropped because previous one was unconsumed
module uart_rx
    import util_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = UART_OVS_DEFAULT,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o
);
    localparam int DIV = uart_div_f(CLK_HZ, BAUD, OVS);
    localparam int TW  = $clog2(OVS);
    localparam int BW  = $clog2(DATA_W);
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
    localparam logic [TW-1:0] T_S2   = TW'(OVS / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    if (DIV < 1 || OVS < 8 || OVS % 2 != 0 || DATA_W < 5 || DATA_W > 9) begin : g_bad_cfg
        $error("uart_rx: unsupported CLK_HZ/BAUD/OVS/DATA_W combination");
    end

    uart_rx_state_e    r_state;
    logic              r_sync1, r_sync2, r_prev;
    logic [TW-1:0]     r_tcnt;
    logic [BW-1:0]     r_bit;
    logic              r_s0, r_s1;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid, r_ferr, r_ovr;
    logic              w_fall, w_restart, w_tick, w_decide, w_maj, w_par_bad, w_good;

    assign w_fall    = r_prev & ~r_sync2;
    assign w_restart = (r_state == ST_IDLE) && w_fall;
    assign w_decide  = w_tick && r_tcnt == T_S2;
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_good    = w_maj & ~w_par_bad;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, r_perr;
    assign w_par_bad    = r_par_bad;
    assign parity_err_o = r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_perr <= w_decide && r_state == ST_STOP && r_par_bad;
            if (w_decide && r_state == ST_PARITY) r_par_bad <= w_maj ^ (^r_shift);
        end
    end
`else
    assign w_par_bad    = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_tcnt  <= '0;
            r_bit   <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= r_valid & ~ready_i;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_fall) begin
                    r_state <= ST_START;
                    r_tcnt  <= '0;
                end
            end else if (w_tick) begin
                // Bit cells keep running on r_tcnt; states only advance at the mid-bit decision.
                r_tcnt <= (r_tcnt == T_LAST) ? '0 : r_tcnt + 1'b1;
                if (r_tcnt == T_S0) r_s0 <= r_sync2;
                if (r_tcnt == T_S1) r_s1 <= r_sync2;
                if (r_tcnt == T_S2) begin
                    case (r_state)
                        ST_START: begin
                            r_state <= w_maj ? ST_IDLE : ST_DATA;
                            r_bit   <= '0;
                        end
                        ST_DATA: begin
                            r_shift <= {w_maj, r_shift[DATA_W-1:1]};
                            r_bit   <= r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (r_bit == B_LAST) r_state <= ST_PARITY;
`else
                            if (r_bit == B_LAST) r_state <= ST_STOP;
`endif
                        end
`ifdef UART_RX_PARITY_EN
                        ST_PARITY: r_state <= ST_STOP;
`endif
                        ST_STOP: begin
                            // Leave at mid-stop so a slightly fast transmitter is still caught.
                            r_state <= ST_IDLE;
                            r_ferr  <= ~w_maj;
                            if (w_good && (!r_valid || ready_i)) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else if (w_good) begin
                                r_ovr <= 1'b1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and hand-sequenced checks of uart_rx at DIV=4 (64 clk/bit).
module tb_uart_rx;
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic [7:0] last_data = 8'h00;

    uart_rx #(.CLK_HZ(7_372_800), .BAUD(115200), .OVS(16), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o) begin
            n_valid++;
            last_data = data_o;
        end
        if (frame_err_o)  n_ferr++;
        if (parity_err_o) n_perr++;
        if (overrun_o)    n_ovr++;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       pbit;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

`ifdef UART_RX_PARITY_EN
    localparam int NV = 8;
`else
    localparam int NV = 5;
`endif
    vec_t vecs[NV];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        rxd = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(pbit);
`endif
        hold_bit(stop);
        hold_bit(1'b1);
    endtask

    task automatic check_frame(input string name, input logic [7:0] d, input int ev, input logic [7:0] ed,
                               input int ef, input int ep, input int eo);
        int v0, f0, p0, o0;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        send_frame(d, 1'b1, ^d);
        check({name, " valid"}, n_valid - v0, ev);
        if (ev != 0) check({name, " data"}, int'(last_data), int'(ed));
        check({name, " ferr"}, n_ferr - f0, ef);
        check({name, " perr"}, n_perr - p0, ep);
        check({name, " ovr"}, n_ovr - o0, eo);
    endtask

    initial begin
        int v0, f0, p0, o0;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 0, 8'h00, 1, 0};
`ifdef UART_RX_PARITY_EN
        vecs[5] = '{8'h07, 1'b1, 1'b0, 0, 8'h00, 0, 1};
        vecs[6] = '{8'h07, 1'b1, 1'b1, 1, 8'h07, 0, 0};
        vecs[7] = '{8'h01, 1'b0, 1'b0, 0, 8'h00, 1, 1};
`endif
        rst_n   = 1'b0;
        rxd     = 1'b1;
        ready_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset data", int'(data_o), 0);
        check("reset valid", int'(valid_o), 0);
        check("reset ferr", int'(frame_err_o), 0);
        check("reset perr", int'(parity_err_o), 0);
        check("reset ovr", int'(overrun_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
            send_frame(vecs[i].d, vecs[i].stop, vecs[i].pbit);
            check($sformatf("vec%0d valid", i), n_valid - v0, vecs[i].exp_valid);
            if (vecs[i].exp_valid != 0) check($sformatf("vec%0d data", i), int'(last_data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d perr", i), n_perr - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d ovr", i), n_ovr - o0, 0);
        end

        v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        rxd = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("glitch valid", n_valid - v0, 0);
        check("glitch errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
        check_frame("after glitch", 8'h3C, 1, 8'h3C, 0, 0, 0);

        ready_i = 1'b0;
        o0 = n_ovr;
        send_frame(8'h11, 1'b1, 1'b0);
        check("ovr first valid", int'(valid_o), 1);
        check("ovr first data", int'(data_o), 'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr pulse", n_ovr - o0, 1);
        check("ovr held data", int'(data_o), 'h11);
        check("ovr held valid", int'(valid_o), 1);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("ovr handshake clears", int'(valid_o), 0);

        f0 = n_ferr; v0 = n_valid; p0 = n_perr;
        rxd = 1'b0;
        repeat (12 * BIT_CLK) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("break ferr", n_ferr - f0, 1);
        check("break valid", n_valid - v0, 0);
        check("break perr", n_perr - p0, 0);
        check_frame("after break", 8'hA5, 1, 8'hA5, 0, 0, 0);

        v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        hold_bit(1'b0);
        for (int i = 0; i < 3; i++) hold_bit(1'b1);
        rxd = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midreset data", int'(data_o), 0);
        check("midreset valid", int'(valid_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (7 * BIT_CLK) @(posedge clk);
        #1;
        check("midreset no output", n_valid - v0, 0);
        check("midreset no errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
        check_frame("after reset", 8'h5A, 1, 8'h5A, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
